alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port list SHALL be, in order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0, req1  input  1 each  operation request from requester 0 / 1
- a0, b0, a1, b1  input  4 each  operands of requester 0 / 1
- sel0, sel1  input  4 each  ALU opcode of requester 0 / 1, passed through unchanged
- gnt0, gnt1  output  1 each  one-cycle grant pulse
- done0, done1  output  1 each  one-cycle result-valid pulse
- result  output  4  captured ALU result, valid while done0 or done1 is high
- alu_a, alu_b, alu_sel  output  4 each  drive the shared combinational ALU
- alu_out  input  4  shared ALU output
- op_count  output  8  completed-operation counter (see Configuration)

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and DONE, encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-004 In IDLE with no request pending, the FSM SHALL stay in IDLE.
REQ-005 In IDLE with at least one request, the block SHALL select a winner, latch its a/b/sel into alu_a/alu_b/alu_sel, and enter ISSUE on the next edge.
REQ-006 Arbitration SHALL be round-robin: a single requester wins; on simultaneous requests the requester not granted last wins.
REQ-007 The last-granted pointer SHALL update only on a grant.
REQ-008 gnt of the winner SHALL be high for exactly the one ISSUE cycle; the other gnt SHALL be low.
REQ-009 At the end of ISSUE, the block SHALL register alu_out into result and enter DONE; ALU settling budget is one full cycle.
REQ-010 In DONE, the done bit of the winner SHALL be high for exactly one cycle, and result SHALL hold the captured value; then the FSM SHALL return to IDLE.
REQ-011 Latency SHALL be: req sampled in IDLE at edge N, gnt high in cycle N+1, done high in cycle N+2; minimum issue interval is 3 cycles.
REQ-012 alu_a/alu_b/alu_sel and result SHALL hold their last values outside ISSUE/DONE.
REQ-013 A requester SHALL hold req and operands stable until its gnt; a req still high at the next IDLE SHALL count as a new request.
REQ-014 A req deasserted before being sampled in IDLE SHALL produce no grant.
REQ-015 The block SHALL never assert gnt0 and gnt1 together, nor done0 and done1 together.

Reset
REQ-016 Asserting rst_n low SHALL immediately force: state IDLE; all gnt and done outputs 0; result, alu_a, alu_b and alu_sel 0; op_count 0; last-granted pointer = requester 1, so requester 0 wins the first tie.
REQ-017 Reset asserted in ISSUE or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-018 After rst_n deasserts, the first request SHALL be sampled at the first rising edge.

Configuration
REQ-019 With macro ALU_ARB_OPCOUNT_EN defined, op_count SHALL increment by 1 on every DONE cycle and saturate at 255.
REQ-020 Without ALU_ARB_OPCOUNT_EN, op_count SHALL be tied to 0 and no counter register SHALL be inferred; all other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL use a stub ALU computing alu_out = (alu_a + alu_b) mod 16 and SHALL cover these scenarios:
- Single request: req0=1, a0=1, b0=1, sel0=0 from IDLE -> gnt0 in cycle N+1 with alu_a=1, alu_b=1, alu_sel=0; done0 and result=2 in cycle N+2; gnt1 and done1 stay 0.
- Tie after reset: req0=req1=1 held high -> grants alternate 0,1,0,1 at 3-cycle spacing; with a1=5, b1=5, sel1=5, the done1 cycle shows result=10 and alu_sel=5.
- Wrap-around: a0=15, b0=3 -> result=2 and alu_sel equals sel0 unchanged.
- Reset mid-operation: rst_n low during ISSUE -> all outputs 0 at once, no done pulse; after release, req1 alone -> gnt1 granted normally.
- Counter: with ALU_ARB_OPCOUNT_EN, 260 back-to-back ops -> op_count = 255; without the macro -> op_count stays 0 throughout.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Optional completed-operation counter is enabled by defining ALU_ARB_OPCOUNT_EN.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [3:0] sel0,
    input  logic [3:0] sel1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] result,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [3:0] alu_out,
    output logic [7:0] op_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       winner_q, winner_d;   // requester of the operation in flight
    logic       last_q, last_d;       // requester granted most recently
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic [3:0] result_q, result_d;
    logic       pick1;

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign pick1 = req1 && (!req0 || !last_q);

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d   = ST_ISSUE;
                    winner_d  = pick1;
                    last_d    = pick1;
                    alu_a_d   = pick1 ? a1   : a0;
                    alu_b_d   = pick1 ? b1   : b0;
                    alu_sel_d = pick1 ? sel1 : sel0;
                end
            end
            ST_ISSUE: begin
                result_d = alu_out;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            winner_q  <= 1'b0;
            last_q    <= 1'b1;
            alu_a_q   <= 4'd0;
            alu_b_q   <= 4'd0;
            alu_sel_q <= 4'd0;
            result_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
        end
    end

    // Pulses are pure state decodes, so reset clears them immediately.
    assign gnt0    = (state_q == ST_ISSUE) && !winner_q;
    assign gnt1    = (state_q == ST_ISSUE) &&  winner_q;
    assign done0   = (state_q == ST_DONE)  && !winner_q;
    assign done1   = (state_q == ST_DONE)  &&  winner_q;
    assign result  = result_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;

`ifdef ALU_ARB_OPCOUNT_EN
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if ((state_q == ST_DONE) && (op_count_q != 8'hFF)) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= 8'd0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 8'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stub adder ALU: table vectors plus
// hand-written tie, reset-abort, late-request and counter sequences.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1, sel0, sel1;
    logic       gnt0, gnt1, done0, done1;
    logic [3:0] result, alu_a, alu_b, alu_sel, alu_out;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign alu_out = alu_a + alu_b;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .sel0(sel0), .sel1(sel1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .op_count(op_count)
    );

    typedef struct {
        logic       r0, r1;
        logic [3:0] a0, b0, s0, a1, b1, s1;
        logic       eg0, eg1;
        logic [3:0] ea, eb, es, eres;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},    {gnt0, gnt1}, 2'b00);
        chk({tag, ".done"},   {done0, done1}, 2'b00);
        chk({tag, ".result"}, result, 4'd0);
        chk({tag, ".alu"},    {alu_a, alu_b, alu_sel}, 12'd0);
        chk({tag, ".opcnt"},  op_count, 8'd0);
    endtask

    initial begin
        vec_t v;
        int   w;
        int   ops;
        logic [7:0] exp_cnt;

        // Expected winners assume the round-robin history starting from reset.
        vecs[0] = '{1'b1, 1'b0, 4'd1,  4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1,  4'd1, 4'd0, 4'd2};
        vecs[1] = '{1'b1, 1'b1, 4'd3,  4'd4, 4'd9, 4'd5, 4'd5, 4'd5, 1'b0, 1'b1, 4'd5,  4'd5, 4'd5, 4'd10};
        vecs[2] = '{1'b1, 1'b1, 4'd15, 4'd3, 4'hC, 4'd2, 4'd2, 4'd1, 1'b1, 1'b0, 4'd15, 4'd3, 4'hC, 4'd2};
        vecs[3] = '{1'b0, 1'b1, 4'd0,  4'd0, 4'd0, 4'd7, 4'd8, 4'd3, 1'b0, 1'b1, 4'd7,  4'd8, 4'd3, 4'd15};
        vecs[4] = '{1'b0, 1'b1, 4'd0,  4'd0, 4'd0, 4'd9, 4'd9, 4'd1, 1'b0, 1'b1, 4'd9,  4'd9, 4'd1, 4'd2};
        vecs[5] = '{1'b1, 1'b1, 4'd6,  4'd2, 4'd4, 4'd1, 4'd1, 4'd1, 1'b1, 1'b0, 4'd6,  4'd2, 4'd4, 4'd8};
        vecs[6] = '{1'b1, 1'b0, 4'd0,  4'd0, 4'hF, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 4'd0,  4'd0, 4'hF, 4'd0};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0; sel0 = 4'd0; sel1 = 4'd0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("idle_after_reset");

        // Table vectors: drive in IDLE, check ISSUE, DONE and the following IDLE.
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            req0 = v.r0; req1 = v.r1;
            a0 = v.a0; b0 = v.b0; sel0 = v.s0;
            a1 = v.a1; b1 = v.b1; sel1 = v.s1;
            @(negedge clk);
            chk($sformatf("v%0d.gnt", i), {gnt0, gnt1}, {v.eg0, v.eg1});
            chk($sformatf("v%0d.alu", i), {alu_a, alu_b, alu_sel}, {v.ea, v.eb, v.es});
            chk($sformatf("v%0d.done_early", i), {done0, done1}, 2'b00);
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d.done", i), {done0, done1}, {v.eg0, v.eg1});
            chk($sformatf("v%0d.result", i), result, v.eres);
            chk($sformatf("v%0d.gnt_off", i), {gnt0, gnt1}, 2'b00);
            @(negedge clk);
            chk($sformatf("v%0d.idle", i), {gnt0, gnt1, done0, done1}, 4'b0000);
            chk($sformatf("v%0d.hold", i), {result, alu_sel}, {v.eres, v.es});
            $display("vec %0d: gnt=%b%b alu_sel=%0h result=%0h", i, v.eg0, v.eg1, v.es, v.eres);
        end

        // Tie held high after reset: grants alternate 0,1,0,1 every 3 cycles.
        do_reset();
        a0 = 4'd1; b0 = 4'd2; sel0 = 4'd7;
        a1 = 4'd5; b1 = 4'd5; sel1 = 4'd5;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            @(negedge clk);
            chk($sformatf("tie%0d.gnt", k), {gnt0, gnt1}, (w == 1) ? 2'b01 : 2'b10);
            @(negedge clk);
            chk($sformatf("tie%0d.done", k), {done0, done1}, (w == 1) ? 2'b01 : 2'b10);
            chk($sformatf("tie%0d.result", k), result, (w == 1) ? 4'd10 : 4'd3);
            chk($sformatf("tie%0d.sel", k), alu_sel, (w == 1) ? 4'd5 : 4'd7);
            @(negedge clk);
            chk($sformatf("tie%0d.gap", k), {gnt0, gnt1, done0, done1}, 4'b0000);
            $display("tie %0d: winner=%0d result=%0h", k, w, result);
        end
        req0 = 1'b0; req1 = 1'b0;

        // A request raised and dropped outside IDLE is never sampled.
        @(negedge clk);
        req0 = 1'b1; a0 = 4'd4; b0 = 4'd4; sel0 = 4'd2;
        @(negedge clk);
        chk("late.gnt", {gnt0, gnt1}, 2'b10);
        @(negedge clk);
        req1 = 1'b1; req0 = 1'b0;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        chk("late.nognt", {gnt0, gnt1}, 2'b00);
        @(negedge clk);
        chk("late.nodone", {done0, done1}, 2'b00);
        $display("late request: no grant");

        // Reset during ISSUE aborts the operation immediately.
        do_reset();
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd7; sel0 = 4'd3;
        @(negedge clk);
        chk("abort.gnt", {gnt0, gnt1}, 2'b10);
        #2;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk_all_zero("abort.now");
        @(negedge clk);
        chk("abort.nodone", {done0, done1}, 2'b00);
        rst_n = 1'b1;
        req1 = 1'b1; a1 = 4'd2; b1 = 4'd3; sel1 = 4'd6;
        @(negedge clk);
        chk("abort.gnt1", {gnt0, gnt1}, 2'b01);
        chk("abort.alu", {alu_a, alu_b, alu_sel}, {4'd2, 4'd3, 4'd6});
        req1 = 1'b0;
        @(negedge clk);
        chk("abort.done1", {done0, done1}, 2'b01);
        chk("abort.result", result, 4'd5);
        $display("abort: recovered, result=%0h", result);
        @(negedge clk);

        // Back-to-back ops on requester 0; counter modelled from observed done pulses.
        do_reset();
        req0 = 1'b1; a0 = 4'd1; b0 = 4'd1; sel0 = 4'd0;
        ops = 0;
        for (int c = 0; c < 260 * 3; c++) begin
            @(negedge clk);
`ifdef ALU_ARB_OPCOUNT_EN
            exp_cnt = (ops > 255) ? 8'd255 : 8'(ops);
`else
            exp_cnt = 8'd0;
`endif
            chk($sformatf("cnt.c%0d", c), op_count, exp_cnt);
            chk($sformatf("cnt.excl%0d", c), {gnt0 & gnt1, done0 & done1}, 2'b00);
            if (done0 || done1) ops++;
        end
        req0 = 1'b0;
        @(negedge clk);
        chk("cnt.ops", ops, 260);
`ifdef ALU_ARB_OPCOUNT_EN
        chk("cnt.final", op_count, 8'd255);
`else
        chk("cnt.final", op_count, 8'd0);
`endif
        $display("counter: ops=%0d op_count=%0d", ops, op_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
